// File: rtl/tx_shift_engine_pkg.sv
// rtl/tx_shift_engine_pkg.sv - shared UART transmit constants, types and baud table
//
// Purpose : common definitions for the transmit serializer slice.
// Contents: FRAME_BITS, default divisor width, FSM state type,
//           standard 100 MHz baud divisors indexed by a 4-bit select.
package tx_shift_engine_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DIV_W_DEF  = 20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  typedef enum logic [3:0] {
    BAUD_300    = 4'd0,
    BAUD_1200   = 4'd1,
    BAUD_2400   = 4'd2,
    BAUD_4800   = 4'd3,
    BAUD_9600   = 4'd4,
    BAUD_19200  = 4'd5,
    BAUD_38400  = 4'd6,
    BAUD_57600  = 4'd7,
    BAUD_115200 = 4'd8,
    BAUD_230400 = 4'd9,
    BAUD_460800 = 4'd10,
    BAUD_921600 = 4'd11
  } baud_sel_e;

  // Clocks per bit at a 100 MHz system clock, rounded to nearest.
  // Unlisted select codes fall back to 115200.
  function automatic logic [DIV_W_DEF-1:0] baud_div_100mhz(input logic [3:0] sel);
    case (sel)
      4'd0:    return 20'd333333;
      4'd1:    return 20'd83333;
      4'd2:    return 20'd41667;
      4'd3:    return 20'd20833;
      4'd4:    return 20'd10417;
      4'd5:    return 20'd5208;
      4'd6:    return 20'd2604;
      4'd7:    return 20'd1736;
      4'd8:    return 20'd868;
      4'd9:    return 20'd434;
      4'd10:   return 20'd217;
      4'd11:   return 20'd109;
      default: return 20'd868;
    endcase
  endfunction

endpackage

// File: rtl/tx_shift_engine_if.sv
// rtl/tx_shift_engine_if.sv - host/decoder side bundle of the transmit serializer
//
// Purpose : groups load request, frame payload and serial/status outputs.
// Signals : Load_Data[7:0], b10, b9, load, baud_div[DIV_W-1:0] (host -> engine)
//           tx, tx_rdy, tx_done                                 (engine -> host)
// Modports: master = host/decoder side, slave = tx_shift_engine.
interface tx_shift_engine_if #(
  parameter int DIV_W = 20
);
  logic [7:0]       Load_Data;
  logic             b10;
  logic             b9;
  logic             load;
  logic [DIV_W-1:0] baud_div;
  logic             tx;
  logic             tx_rdy;
  logic             tx_done;

  modport master (
    output Load_Data, b10, b9, load, baud_div,
    input  tx, tx_rdy, tx_done
  );

  modport slave (
    input  Load_Data, b10, b9, load, baud_div,
    output tx, tx_rdy, tx_done
  );
endinterface

// File: rtl/tx_shift_engine_baud_tick_gen.sv
// rtl/tx_shift_engine_baud_tick_gen.sv - per-bit timing counter for the serializer
//
// Purpose : counts clocks within one bit period and flags the last clock.
// Ports   : clk, reset_n (async, active-low)
//           clr    - force count to 0 (frame start)
//           en     - count while a frame is in progress
//           div_q  - clocks per bit, already clamped to >= 2
//           tick   - high on the final clock of each bit period
module baud_tick_gen #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div_q,
  output logic             tick
);

  logic [DIV_W-1:0] baud_cnt;

  // Compare against div_q-1 so the count restarts before it can wrap.
  assign tick = en && (baud_cnt == div_q - DIV_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
    end else if (clr) begin
      baud_cnt <= '0;
    end else if (en) begin
      baud_cnt <= tick ? '0 : baud_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tx_shift_engine.sv
// rtl/tx_shift_engine.sv - UART transmit frame serializer
//
// Purpose : captures {b10, b9, Load_Data, start 0} on an accepted load and
//           shifts it out LSB-first, one bit per div_q clocks.
// Ports   : clk, reset_n (async, active-low)
//           bus (tx_shift_engine_if.slave):
//             Load_Data, b10, b9, load, baud_div in; tx, tx_rdy, tx_done out
module tx_shift_engine
  import tx_shift_engine_pkg::*;
#(
  parameter int DIV_W      = 20,
  parameter int FRAME_BITS = tx_shift_engine_pkg::FRAME_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  tx_shift_engine_if.slave    bus
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [10:0]      sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic             tick_clr, tick_en, tick;

  baud_tick_gen #(.DIV_W(DIV_W)) u_baud_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tick_clr),
    .en      (tick_en),
    .div_q   (div_q),
    .tick    (tick)
  );

  // tx is the shift register LSB: the start 0 appears on the load edge, and
  // the 1-fill leaves the line idle-high once all 11 bits have shifted out.
  assign bus.tx      = sr_q[0];
  assign bus.tx_rdy  = rdy_q;
  assign bus.tx_done = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sr_q      <= '1;
      bit_cnt_q <= '0;
      div_q     <= DIV_W'(2);
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    rdy_d     = rdy_q;
    done_d    = 1'b0;
    tick_clr  = 1'b0;
    tick_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (bus.load && rdy_q) begin
          state_d   = ST_SHIFT;
          sr_d      = {bus.b10, bus.b9, bus.Load_Data, 1'b0};
          // A divisor below 2 would leave no room for the compare; clamp.
          div_d     = (bus.baud_div < DIV_W'(2)) ? DIV_W'(2) : bus.baud_div;
          bit_cnt_d = '0;
          rdy_d     = 1'b0;
          tick_clr  = 1'b1;
        end
      end

      ST_SHIFT: begin
        tick_en = 1'b1;
        if (bit_cnt_q > LAST_BIT) begin
          // Unreachable count: drop back to idle with the line released.
          state_d   = ST_IDLE;
          sr_d      = '1;
          bit_cnt_d = '0;
          rdy_d     = 1'b1;
          tick_clr  = 1'b1;
        end else if (tick) begin
          sr_d      = {1'b1, sr_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            rdy_d     = 1'b1;
            done_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sr_d    = '1;
        rdy_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_tx_shift_engine.sv
// tb/tb_tx_shift_engine.sv - self-checking bench for tx_shift_engine
module tb_tx_shift_engine;

  localparam int DW = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tx_shift_engine_if #(.DIV_W(DW)) bus ();

  tx_shift_engine #(.DIV_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame model: once a load is accepted, the output after k clocks is frame
  // bit k/D until k reaches 11*D, where the line idles and done pulses.
  logic        m_busy = 1'b0;
  int          m_k = 0;
  int          m_d = 2;
  logic [10:0] m_frame = '1;
  logic        exp_tx = 1'b1;
  logic        exp_rdy = 1'b1;
  logic        exp_done = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_k = 0;
      exp_tx = 1'b1; exp_rdy = 1'b1; exp_done = 1'b0;
    end else if (m_busy) begin
      m_k++;
      exp_done = 1'b0;
      if (m_k == 11 * m_d) begin
        m_busy = 1'b0; exp_tx = 1'b1; exp_rdy = 1'b1; exp_done = 1'b1;
      end else begin
        exp_tx = m_frame[m_k / m_d];
      end
    end else begin
      exp_done = 1'b0;
      if (bus.load) begin
        m_busy  = 1'b1; m_k = 0;
        m_d     = (bus.baud_div < 2) ? 2 : int'(bus.baud_div);
        m_frame = {bus.b10, bus.b9, bus.Load_Data, 1'b0};
        exp_tx  = 1'b0; exp_rdy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("sb_tx", 32'(bus.tx), 32'(exp_tx));
      check("sb_tx_rdy", 32'(bus.tx_rdy), 32'(exp_rdy));
      check("sb_tx_done", 32'(bus.tx_done), 32'(exp_done));
    end
  end

  // Drives one load, then observes ncyc cycles (k = clocks after the load edge).
  task automatic run(input logic [7:0] data, input logic hb10, input logic hb9,
                     input int div, input int ncyc, input int busy_at,
                     input int chg_at, input logic hold,
                     output logic [10:0] bits, output int rl, output int dc,
                     output int dk);
    int d;
    d = (div < 2) ? 2 : div;
    bus.Load_Data = data; bus.b10 = hb10; bus.b9 = hb9;
    bus.baud_div = DW'(div); bus.load = 1'b1;
    rl = 0; dc = 0; dk = -1; bits = '1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (!bus.tx_rdy) rl++;
      if (bus.tx_done) begin
        dc++;
        if (dk < 0) dk = k;
      end
      if ((k % d) == 1 && (k / d) < 11) bits[k / d] = bus.tx;
      if (!hold) bus.load = (k == busy_at);
      if (k == busy_at) bus.Load_Data = 8'hAA;
      if (k == chg_at) begin
        bus.baud_div = DW'(8); bus.b10 = 1'b0;
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !bus.tx_rdy; i++) @(negedge clk);
    @(negedge clk);
    check("wait_idle", 32'(bus.tx_rdy), 32'd1);
  endtask

  logic [10:0] bits;
  int rl, dc, dk;

  initial begin
    bus.load = 1'b0; bus.Load_Data = 8'h00; bus.b10 = 1'b1; bus.b9 = 1'b1;
    bus.baud_div = DW'(4);
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_rdy", 32'(bus.tx_rdy), 32'd1);
    check("reset_done", 32'(bus.tx_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frame: 0,1,1,1,1,0,0,0,0,0,1
    run(8'h0F, 1'b1, 1'b0, 4, 50, -1, -1, 1'b0, bits, rl, dc, dk);
    check("basic_bits", 32'(bits), 32'h41E);
    check("basic_rdy_low", rl, 44);
    check("basic_done_cnt", dc, 1);
    check("basic_done_at", dk, 44);
    check("basic_tx_after", 32'(bus.tx), 32'd1);
    wait_idle();

    // Load while busy (clock 10) is ignored.
    run(8'h0F, 1'b1, 1'b0, 4, 60, 9, -1, 1'b0, bits, rl, dc, dk);
    check("busy_bits", 32'(bits), 32'h41E);
    check("busy_rdy_low", rl, 44);
    check("busy_done_cnt", dc, 1);
    check("busy_done_at", dk, 44);
    wait_idle();

    // Load held high: next frame accepted on the first tx_rdy=1 edge.
    run(8'h55, 1'b1, 1'b1, 2, 50, -1, -1, 1'b1, bits, rl, dc, dk);
    check("b2b_bits", 32'(bits), 32'h6AA);
    check("b2b_done_cnt", dc, 2);
    check("b2b_first_done", dk, 22);
    check("b2b_rdy_low", rl, 48);
    wait_idle();

    // Divisor clamp to 2 for 0 and 1.
    run(8'h80, 1'b1, 1'b1, 0, 30, -1, -1, 1'b0, bits, rl, dc, dk);
    check("clamp0_bits", 32'(bits), 32'h700);
    check("clamp0_rdy_low", rl, 22);
    check("clamp0_done_at", dk, 22);
    wait_idle();
    run(8'h80, 1'b1, 1'b1, 1, 30, -1, -1, 1'b0, bits, rl, dc, dk);
    check("clamp1_bits", 32'(bits), 32'h700);
    check("clamp1_rdy_low", rl, 22);
    check("clamp1_done_at", dk, 22);
    wait_idle();

    // Mid-frame change of baud_div/b10 does not affect the frame.
    run(8'h0F, 1'b1, 1'b0, 4, 50, -1, 4, 1'b0, bits, rl, dc, dk);
    check("chg_bits", 32'(bits), 32'h41E);
    check("chg_rdy_low", rl, 44);
    check("chg_done_at", dk, 44);
    wait_idle();

    // Asynchronous reset between edges, mid-frame.
    run(8'hFF, 1'b0, 1'b0, 4, 13, -1, -1, 1'b0, bits, rl, dc, dk);
    check("abort_busy", 32'(bus.tx_rdy), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", 32'(bus.tx), 32'd1);
    check("abort_rdy", 32'(bus.tx_rdy), 32'd1);
    check("abort_done", 32'(bus.tx_done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(bus.tx_done), 32'd0);
    run(8'h3C, 1'b1, 1'b1, 4, 50, -1, -1, 1'b0, bits, rl, dc, dk);
    check("post_rst_bits", 32'(bits), 32'h678);
    check("post_rst_done_cnt", dc, 1);
    check("post_rst_done_at", dk, 44);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
